// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the execute-stage multi-cycle units.
package cpu_pkg;

   localparam int DIV_CYCLES = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W:0]   rem_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W:0]   rem_o,
   output logic              q_bit_o
);

   logic [DATA_W:0] diff;

   // rem_i < 2*divisor, so the difference always fits and its top bit is a valid sign.
   assign diff    = rem_i - {1'b0, divisor_i};
   assign q_bit_o = ~diff[DATA_W];
   assign rem_o   = q_bit_o ? diff : rem_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32 restoring steps on magnitudes, then sign correction.
//   state | meaning
//   IDLE  | waiting for a divide; ex_ok_o = ~start_i
//   BUSY  | one quotient bit per cycle, pipeline held
//   DONE  | results valid, held until the instruction leaves EX
module div_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              pipe_stall_i,
   input  logic              flush_i,
   output logic              ex_ok_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   div_state_e        state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [DATA_W:0]   rem_q, rem_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] dvsr_q, dvsr_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              sgn_q, sgn_d;

   logic [DATA_W-1:0] dvd_abs, dvs_abs, quot_step;
   logic [DATA_W:0]   rem_shift, rem_step;
   logic              q_bit, div_zero, last_step;

   assign dvd_abs   = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
   assign dvs_abs   = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;
   assign div_zero  = (divisor_i == '0);
   assign last_step = (cnt_q == 6'(DIV_CYCLES - 1));

   // The dividend magnitude sits in quot_q and is shifted out MSB-first as quotient bits shift in.
   assign rem_shift = {rem_q[DATA_W-1:0], quot_q[DATA_W-1]};
   assign quot_step = {quot_q[DATA_W-2:0], q_bit};

   div_step #(.DATA_W(DATA_W)) u_div_step (
      .rem_i     (rem_shift),
      .divisor_i (dvsr_q),
      .rem_o     (rem_step),
      .q_bit_o   (q_bit)
   );

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         dvsr_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         dvsr_q  <= dvsr_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         sgn_q   <= sgn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i) state_d = div_zero ? DONE : BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (!pipe_stall_i) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      dvsr_d  = dvsr_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      sgn_d   = sgn_q;
      if (!flush_i) begin
         if (state_q == IDLE && start_i) begin
            if (div_zero) begin
               hi_d = dividend_i;
               lo_d = '1;
            end else begin
               cnt_d   = '0;
               rem_d   = '0;
               quot_d  = dvd_abs;
               dvsr_d  = dvs_abs;
               q_neg_d = signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
               r_neg_d = dividend_i[DATA_W-1];
               sgn_d   = signed_i;
            end
         end else if (state_q == BUSY) begin
            cnt_d  = cnt_q + 6'd1;
            rem_d  = rem_step;
            quot_d = quot_step;
            if (last_step) begin
               lo_d = q_neg_q ? -quot_step : quot_step;
               hi_d = (r_neg_q && sgn_q) ? -rem_step[DATA_W-1:0] : rem_step[DATA_W-1:0];
            end
         end
      end
   end

   // A pending flush must never be stalled by the divider.
   always_comb begin
      ex_ok_o = 1'b1;
      if (!flush_i) begin
         case (state_q)
            IDLE:    ex_ok_o = ~start_i;
            BUSY:    ex_ok_o = 1'b0;
            default: ex_ok_o = 1'b1;
         endcase
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by zero, stall, flush, reset.
module tb_div_unit;
   import cpu_pkg::*;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        start_i;
   logic        signed_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        pipe_stall_i;
   logic        flush_i;
   logic        ex_ok_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_vec = 0;
   int n_err = 0;

   div_unit #(.DATA_W(32)) dut (
      .clk_i        (clk_i),
      .resetn_i     (resetn_i),
      .start_i      (start_i),
      .signed_i     (signed_i),
      .dividend_i   (dividend_i),
      .divisor_i    (divisor_i),
      .pipe_stall_i (pipe_stall_i),
      .flush_i      (flush_i),
      .ex_ok_o      (ex_ok_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Starts a divide on a falling edge and returns in the first cycle ex_ok_o is high.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat);
      int lat = 0;
      @(negedge clk_i);
      start_i    = 1'b1;
      signed_i   = sgn;
      dividend_i = a;
      divisor_i  = b;
      #1;
      while (!ex_ok_o && lat < 100) begin
         lat++;
         @(negedge clk_i);
         #1;
      end
      chk_eq({tag, " lat"}, 32'(lat), 32'(exp_lat));
      chk_eq({tag, " lo"}, lo_o, exp_lo);
      chk_eq({tag, " hi"}, hi_o, exp_hi);
   endtask

   task automatic leave_done(input string tag);
      @(negedge clk_i);
      start_i = 1'b0;
      #1;
      chk_eq({tag, " idle"}, 32'(dut.state_q), 32'(IDLE));
      chk_eq({tag, " ex_ok idle"}, 32'(ex_ok_o), 32'd1);
   endtask

   initial begin
      resetn_i     = 1'b0;
      start_i      = 1'b0;
      signed_i     = 1'b0;
      dividend_i   = '0;
      divisor_i    = '0;
      pipe_stall_i = 1'b0;
      flush_i      = 1'b0;
      @(negedge clk_i);
      #1;
      chk_eq("rst hi", hi_o, 32'd0);
      chk_eq("rst lo", lo_o, 32'd0);
      chk_eq("rst ex_ok", 32'(ex_ok_o), 32'd1);
      @(negedge clk_i);
      resetn_i = 1'b1;

      run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
      leave_done("divu 100/7");
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      leave_done("div -7/2");
      run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
      leave_done("div 7/-2");
      run_div("div minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
      leave_done("div minneg");
      run_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 33);
      leave_done("divu big");
      run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
      leave_done("divu 5/0");
      run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);
      leave_done("div -5/0");

      // Completion under an external stall with start held: 20 / -3 = -6 rem 2.
      pipe_stall_i = 1'b1;
      run_div("div stall", 1'b1, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd2, 33);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         #1;
         chk_eq("stall ex_ok", 32'(ex_ok_o), 32'd1);
         chk_eq("stall state", 32'(dut.state_q), 32'(DONE));
         chk_eq("stall lo", lo_o, 32'hFFFF_FFFA);
      end
      @(negedge clk_i);
      pipe_stall_i = 1'b0;
      #1;
      chk_eq("stall drop ex_ok", 32'(ex_ok_o), 32'd1);
      leave_done("div stall");

      // Flush in the middle of a division, then a fresh divide.
      @(negedge clk_i);
      start_i    = 1'b1;
      signed_i   = 1'b0;
      dividend_i = 32'd1000;
      divisor_i  = 32'd3;
      for (int i = 0; i < 10; i++) @(negedge clk_i);
      flush_i = 1'b1;
      #1;
      chk_eq("flush ex_ok", 32'(ex_ok_o), 32'd1);
      @(negedge clk_i);
      flush_i = 1'b0;
      start_i = 1'b0;
      #1;
      chk_eq("flush idle", 32'(dut.state_q), 32'(IDLE));
      chk_eq("flush lo kept", lo_o, 32'hFFFF_FFFA);
      chk_eq("flush hi kept", hi_o, 32'd2);
      run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);
      leave_done("divu 9/3");

      // Flush wins over start in IDLE.
      @(negedge clk_i);
      start_i   = 1'b1;
      flush_i   = 1'b1;
      divisor_i = 32'd5;
      #1;
      chk_eq("flush prio ex_ok", 32'(ex_ok_o), 32'd1);
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      #1;
      chk_eq("flush prio idle", 32'(dut.state_q), 32'(IDLE));

      // Reset in the middle of BUSY.
      @(negedge clk_i);
      start_i    = 1'b1;
      signed_i   = 1'b1;
      dividend_i = 32'hFFFF_FC18;
      divisor_i  = 32'd7;
      for (int i = 0; i < 20; i++) @(negedge clk_i);
      resetn_i = 1'b0;
      #1;
      chk_eq("busy rst hi", hi_o, 32'd0);
      chk_eq("busy rst lo", lo_o, 32'd0);
      chk_eq("busy rst ex_ok start", 32'(ex_ok_o), 32'd0);
      start_i = 1'b0;
      #1;
      chk_eq("busy rst ex_ok", 32'(ex_ok_o), 32'd1);
      @(negedge clk_i);
      resetn_i = 1'b1;
      @(negedge clk_i);
      #1;
      chk_eq("post rst idle", 32'(dut.state_q), 32'(IDLE));
      chk_eq("post rst ex_ok", 32'(ex_ok_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
